// File: rtl/onewire_pkg.sv
// Shared definitions for the 1-Wire slave blocks: frame geometry, CRC8
// polynomial, FSM state encodings and the serial CRC8 step function.
package onewire_pkg;

    localparam int DATA_BITS  = 56;
    localparam int CRC_BITS   = 8;
    localparam int FRAME_BITS = 64;

    // Reflected form of x^8 + x^5 + x^4 + 1 (Dallas/Maxim CRC8).
    localparam logic [7:0] CRC_POLY_REFL = 8'h8C;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        ARMED      = 3'd1,
        SLOT       = 3'd2,
        RECOVER    = 3'd3,
        PRES_WAIT  = 3'd4,
        PRES_DRIVE = 3'd5
    } ow_state_e;

    // One serial CRC8 step, data bit entering at the LSB side.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic b);
        logic       fb;
        logic [7:0] nxt;
        fb  = crc[0] ^ b;
        nxt = {1'b0, crc[7:1]};
        if (fb) begin
            nxt = nxt ^ CRC_POLY_REFL;
        end else begin
            nxt = {1'b0, crc[7:1]};
        end
        return nxt;
    endfunction

    // Largest of three integers, used to size shared timers.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) begin
            m = b;
        end else begin
            m = m;
        end
        if (c > m) begin
            m = c;
        end else begin
            m = m;
        end
        return m;
    endfunction

endpackage

// File: rtl/onewire_crc8.sv
// Serial Dallas/Maxim CRC8 register. One data bit per enabled cycle;
// clr has priority over en and returns the register to zero.
module onewire_crc8
    import onewire_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic                en,
    input  logic                bit_in,
    output logic [CRC_BITS-1:0] crc
);

    // CRC state: clear, advance by one bit, or hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= {CRC_BITS{1'b0}};
        end else if (clr) begin
            crc <= {CRC_BITS{1'b0}};
        end else if (en) begin
            crc <= crc8_step(crc, bit_in);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/onewire_slave_tx.sv
// Slave-side 1-Wire transmitter: answers 64 master read slots with a 56-bit
// payload (LSB first) followed by its CRC8. A 0 bit is sent by holding the
// line low for T_HOLD cycles after the master's falling edge.
// A bus-reset low (T_RSTL cycles) aborts the frame and re-arms it from bit 0.
// Optional: define ONEWIRE_PRESENCE_EN to emit a presence pulse after a reset.
module onewire_slave_tx
    import onewire_pkg::*;
#(
    parameter int T_HOLD = 15,
    parameter int T_RSTL = 120,
    parameter int T_PDH  = 15,
    parameter int T_PDL  = 60
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] i_tx_data,
    input  logic                 i_tx_start,
    input  logic                 i_line,
    output logic                 o_drive_low,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [CRC_BITS-1:0]  o_crc
);

    localparam int CNT_W = $clog2(FRAME_BITS);
    localparam int IDX_W = $clog2(CRC_BITS);
    localparam int LOW_W = $clog2(T_RSTL + 1);
    localparam int TMR_W = $clog2(max3(T_HOLD, T_PDH, T_PDL) + 1);

    localparam logic [LOW_W-1:0] RSTL_C      = LOW_W'(T_RSTL);
    localparam logic [TMR_W-1:0] HOLD_LAST_C = TMR_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] DATA_END_C  = CNT_W'(DATA_BITS);
    localparam logic [CNT_W-1:0] LAST_BIT_C  = CNT_W'(FRAME_BITS - 1);
`ifdef ONEWIRE_PRESENCE_EN
    localparam logic [TMR_W-1:0] PDH_LAST_C  = TMR_W'(T_PDH - 1);
    localparam logic [TMR_W-1:0] PDL_LAST_C  = TMR_W'(T_PDL - 1);
`endif

    // Line synchronizer and edge detection
    logic sync1_r;
    logic line_s_r;
    logic line_prev_r;
    logic fall_s;

    // FSM and datapath state
    ow_state_e            state_r,   state_nxt_s;
    logic [CNT_W-1:0]     bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shreg_r,   shreg_nxt_s;
    logic [DATA_BITS-1:0] payload_r, payload_nxt_s;
    logic [TMR_W-1:0]     tmr_r,     tmr_nxt_s;
    logic [LOW_W-1:0]     low_cnt_r, low_cnt_nxt_s;
    logic                 drive_r,   drive_nxt_s;
    logic                 busy_r,    busy_nxt_s;
    logic                 done_r,    done_nxt_s;

    // CRC interface
    logic                 crc_clr_s;
    logic                 crc_en_s;
    logic                 crc_bit_s;
    logic [CRC_BITS-1:0]  crc_s;

    logic                 cur_bit_s;
    logic                 rst_hit_s;
    logic                 abort_s;

`ifdef ONEWIRE_PRESENCE_EN
    logic                 rst_pend_r, rst_pend_nxt_s;
    logic                 pres_go_s;
`endif

    // Two-flop synchronizer plus previous-sample flop; idle level is released (1).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_r     <= 1'b1;
            line_s_r    <= 1'b1;
            line_prev_r <= 1'b1;
        end else begin
            sync1_r     <= i_line;
            line_s_r    <= sync1_r;
            line_prev_r <= line_s_r;
        end
    end

    assign fall_s    = line_prev_r & ~line_s_r;
    assign rst_hit_s = (low_cnt_r == RSTL_C);
    assign abort_s   = rst_hit_s && (state_r != IDLE);

`ifdef ONEWIRE_PRESENCE_EN
    assign pres_go_s = rst_pend_r && line_s_r && ((state_r == IDLE) || (state_r == ARMED));

    // Remember a detected bus reset until the line is released again.
    always_comb begin
        rst_pend_nxt_s = rst_pend_r;
        if (pres_go_s) begin
            rst_pend_nxt_s = 1'b0;
        end else if (rst_hit_s && !line_s_r) begin
            rst_pend_nxt_s = 1'b1;
        end else begin
            rst_pend_nxt_s = rst_pend_r;
        end
    end
`endif

    // Bit for the current slot: payload bits first, then the frozen CRC LSB first.
    always_comb begin
        if (bit_cnt_r < DATA_END_C) begin
            cur_bit_s = shreg_r[0];
        end else begin
            cur_bit_s = crc_s[bit_cnt_r[IDX_W-1:0]];
        end
    end

    // Low-time counter; our own drive phases never count toward a bus reset.
    always_comb begin
        low_cnt_nxt_s = low_cnt_r;
        if (line_s_r) begin
            low_cnt_nxt_s = {LOW_W{1'b0}};
        end else if ((state_r == SLOT) || (state_r == PRES_DRIVE)) begin
            low_cnt_nxt_s = {LOW_W{1'b0}};
        end else if (rst_hit_s) begin
            low_cnt_nxt_s = low_cnt_r;
        end else begin
            low_cnt_nxt_s = low_cnt_r + LOW_W'(1);
        end
    end

    // Next-state and next-output logic for the transmit FSM.
    always_comb begin
        state_nxt_s   = state_r;
        bit_cnt_nxt_s = bit_cnt_r;
        shreg_nxt_s   = shreg_r;
        payload_nxt_s = payload_r;
        tmr_nxt_s     = tmr_r;
        drive_nxt_s   = drive_r;
        busy_nxt_s    = busy_r;
        done_nxt_s    = 1'b0;
        crc_clr_s     = 1'b0;
        crc_en_s      = 1'b0;
        crc_bit_s     = cur_bit_s;

`ifdef ONEWIRE_PRESENCE_EN
        if (pres_go_s) begin
            state_nxt_s = PRES_WAIT;
            tmr_nxt_s   = {TMR_W{1'b0}};
            drive_nxt_s = 1'b0;
        end else
`endif
        if (abort_s) begin
            // Bus reset seen mid-frame: restart the frame from bit 0.
            drive_nxt_s   = 1'b0;
            bit_cnt_nxt_s = {CNT_W{1'b0}};
            shreg_nxt_s   = payload_r;
            tmr_nxt_s     = {TMR_W{1'b0}};
            crc_clr_s     = 1'b1;
            state_nxt_s   = busy_r ? ARMED : IDLE;
        end else begin
            case (state_r)
                IDLE: begin
                    drive_nxt_s = 1'b0;
                    if (i_tx_start) begin
                        payload_nxt_s = i_tx_data;
                        shreg_nxt_s   = i_tx_data;
                        bit_cnt_nxt_s = {CNT_W{1'b0}};
                        crc_clr_s     = 1'b1;
                        busy_nxt_s    = 1'b1;
                        state_nxt_s   = ARMED;
                    end else begin
                        state_nxt_s   = IDLE;
                    end
                end
                ARMED: begin
                    if (fall_s) begin
                        crc_en_s    = (bit_cnt_r < DATA_END_C);
                        drive_nxt_s = ~cur_bit_s;
                        tmr_nxt_s   = {TMR_W{1'b0}};
                        state_nxt_s = SLOT;
                    end else begin
                        drive_nxt_s = 1'b0;
                    end
                end
                SLOT: begin
                    if (tmr_r == HOLD_LAST_C) begin
                        drive_nxt_s = 1'b0;
                        tmr_nxt_s   = {TMR_W{1'b0}};
                        state_nxt_s = RECOVER;
                    end else begin
                        tmr_nxt_s   = tmr_r + TMR_W'(1);
                    end
                end
                RECOVER: begin
                    if (line_s_r) begin
                        bit_cnt_nxt_s = bit_cnt_r + CNT_W'(1);
                        shreg_nxt_s   = {1'b0, shreg_r[DATA_BITS-1:1]};
                        if (bit_cnt_r == LAST_BIT_C) begin
                            done_nxt_s    = 1'b1;
                            busy_nxt_s    = 1'b0;
                            bit_cnt_nxt_s = {CNT_W{1'b0}};
                            state_nxt_s   = IDLE;
                        end else begin
                            state_nxt_s   = ARMED;
                        end
                    end else begin
                        state_nxt_s = RECOVER;
                    end
                end
`ifdef ONEWIRE_PRESENCE_EN
                PRES_WAIT: begin
                    if (tmr_r == PDH_LAST_C) begin
                        drive_nxt_s = 1'b1;
                        tmr_nxt_s   = {TMR_W{1'b0}};
                        state_nxt_s = PRES_DRIVE;
                    end else begin
                        drive_nxt_s = 1'b0;
                        tmr_nxt_s   = tmr_r + TMR_W'(1);
                    end
                end
                PRES_DRIVE: begin
                    if (tmr_r == PDL_LAST_C) begin
                        drive_nxt_s = 1'b0;
                        tmr_nxt_s   = {TMR_W{1'b0}};
                        state_nxt_s = busy_r ? ARMED : IDLE;
                    end else begin
                        drive_nxt_s = 1'b1;
                        tmr_nxt_s   = tmr_r + TMR_W'(1);
                    end
                end
`endif
                default: begin
                    drive_nxt_s = 1'b0;
                    busy_nxt_s  = 1'b0;
                    state_nxt_s = IDLE;
                end
            endcase
        end
    end

    // State and datapath registers; reset releases the line immediately.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            bit_cnt_r <= {CNT_W{1'b0}};
            shreg_r   <= {DATA_BITS{1'b0}};
            payload_r <= {DATA_BITS{1'b0}};
            tmr_r     <= {TMR_W{1'b0}};
            low_cnt_r <= {LOW_W{1'b0}};
            drive_r   <= 1'b0;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            shreg_r   <= shreg_nxt_s;
            payload_r <= payload_nxt_s;
            tmr_r     <= tmr_nxt_s;
            low_cnt_r <= low_cnt_nxt_s;
            drive_r   <= drive_nxt_s;
            busy_r    <= busy_nxt_s;
            done_r    <= done_nxt_s;
        end
    end

`ifdef ONEWIRE_PRESENCE_EN
    // Pending-presence flag register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rst_pend_r <= 1'b0;
        end else begin
            rst_pend_r <= rst_pend_nxt_s;
        end
    end
`endif

    onewire_crc8 u_crc (
        .clk    (clk),
        .rst_n  (reset),
        .clr    (crc_clr_s),
        .en     (crc_en_s),
        .bit_in (crc_bit_s),
        .crc    (crc_s)
    );

    assign o_drive_low = drive_r;
    assign o_busy      = busy_r;
    assign o_done      = done_r;
    assign o_crc       = crc_s;

endmodule

// File: tb/tb_onewire_slave_tx.sv
// Directed bench for onewire_slave_tx: a master model issues read slots on a
// wired-AND line and decodes the slave's response bits.
module tb_onewire_slave_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [55:0] tx_data;
    logic        tx_start;
    logic        master_low;
    logic        bus_line;
    logic        drive_low;
    logic        busy;
    logic        done;
    logic [7:0]  crc;

    int          checks = 0;
    int          errors = 0;
    int          done_total = 0;
    logic [63:0] rx_bits;
    int          bad_slots;
    int          held15;

    localparam logic [55:0] ROM_PAYLOAD = 56'h00000001B81C02;
    localparam logic [63:0] ROM_FRAME   = 64'hA200000001B81C02;

    assign bus_line = ~(drive_low | master_low);

    onewire_slave_tx dut (
        .clk         (clk),
        .reset       (reset),
        .i_tx_data   (tx_data),
        .i_tx_start  (tx_start),
        .i_line      (bus_line),
        .o_drive_low (drive_low),
        .o_busy      (busy),
        .o_done      (done),
        .o_crc       (crc)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_total <= done_total + 1;
    end

    function automatic logic [7:0] crc_model(input logic [55:0] d);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int i = 0; i < 56; i++) begin
            fb = c[0] ^ d[i];
            c  = c >> 1;
            if (fb) c = c ^ 8'h8C;
        end
        return c;
    endfunction

    task automatic load_frame(input logic [55:0] d);
        @(negedge clk);
        tx_data  = d;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    // One 70-cycle master read slot; starts and ends on a falling clock edge.
    task automatic do_slot(input bit poke, input int ext_at, output bit b, output int dcnt);
        master_low = 1'b1;
        @(negedge clk);
        master_low = 1'b0;
        dcnt = 0;
        for (int k = 1; k < 70; k++) begin
            if (ext_at > 0 && k == ext_at) master_low = 1'b1;
            if (ext_at > 0 && k == ext_at + 10) master_low = 1'b0;
            if (poke && k == 30) begin tx_data = 56'h0; tx_start = 1'b1; end
            if (poke && k == 31) tx_start = 1'b0;
            if (drive_low) dcnt++;
            @(negedge clk);
        end
        b = (dcnt == 0);
    endtask

    task automatic run_slots(input int first, input int n, input bit poke);
        bit b;
        int d;
        for (int i = 0; i < n; i++) begin
            do_slot(poke && ((first + i) < 60), 0, b, d);
            rx_bits[first + i] = b;
            if (d != 0 && d != 15) bad_slots++;
            if (d == 15) held15++;
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        checks++; if (drive_low !== 1'b0) begin errors++; $display("FAIL reset_drive got %b want 0", drive_low); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (crc !== 8'h00) begin errors++; $display("FAIL reset_crc got %h want 00", crc); end
    endtask

    task automatic test_known_rom;
        int d0;
        d0 = done_total;
        load_frame(ROM_PAYLOAD);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rom_busy got %b want 1", busy); end
        rx_bits = 64'h0; bad_slots = 0; held15 = 0;
        run_slots(0, 64, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (rx_bits !== ROM_FRAME) begin errors++; $display("FAIL rom_stream got %h want %h", rx_bits, ROM_FRAME); end
        checks++; if (crc !== 8'hA2) begin errors++; $display("FAIL rom_crc got %h want a2", crc); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL rom_done got %0d want 1", done_total - d0); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rom_busy_end got %b want 0", busy); end
        checks++; if (bad_slots != 0) begin errors++; $display("FAIL rom_hold_len got %0d want 0", bad_slots); end
    endtask

    task automatic test_zero_frame;
        int d0;
        d0 = done_total;
        load_frame(56'h0);
        rx_bits = 64'hFFFF_FFFF_FFFF_FFFF; bad_slots = 0; held15 = 0;
        run_slots(0, 64, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (held15 != 64) begin errors++; $display("FAIL zero_hold15 got %0d want 64", held15); end
        checks++; if (rx_bits !== 64'h0) begin errors++; $display("FAIL zero_stream got %h want 0", rx_bits); end
        checks++; if (crc !== 8'h00) begin errors++; $display("FAIL zero_crc got %h want 00", crc); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL zero_done got %0d want 1", done_total - d0); end
    endtask

    task automatic test_ones_busy_start;
        logic [55:0] ones;
        logic [7:0]  exp_crc;
        logic [63:0] exp_frame;
        int d0;
        ones = 56'hFF_FFFF_FFFF_FFFF;
        exp_crc = crc_model(ones);
        exp_frame = {exp_crc, ones};
        d0 = done_total;
        load_frame(ones);
        rx_bits = 64'h0; bad_slots = 0; held15 = 0;
        run_slots(0, 64, 1'b1);
        repeat (3) @(negedge clk);
        checks++; if (rx_bits[55:0] !== ones) begin errors++; $display("FAIL ones_data got %h want %h", rx_bits[55:0], ones); end
        checks++; if (rx_bits !== exp_frame) begin errors++; $display("FAIL ones_stream got %h want %h", rx_bits, exp_frame); end
        checks++; if (crc !== exp_crc) begin errors++; $display("FAIL ones_crc got %h want %h", crc, exp_crc); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL ones_done got %0d want 1", done_total - d0); end
    endtask

    task automatic test_bus_reset;
        logic [63:0] exp_frame;
        int d0;
        int first;
        int width;
        exp_frame = ROM_FRAME;
        d0 = done_total;
        load_frame(ROM_PAYLOAD);
        rx_bits = 64'h0; bad_slots = 0; held15 = 0;
        run_slots(0, 20, 1'b0);
        checks++; if (rx_bits[19:0] !== exp_frame[19:0]) begin errors++; $display("FAIL busrst_pre got %h want %h", rx_bits[19:0], exp_frame[19:0]); end
        master_low = 1'b1;
        repeat (200) @(negedge clk);
        master_low = 1'b0;
        first = -1; width = 0;
        for (int k = 0; k < 150; k++) begin
            if (drive_low) begin
                if (first < 0) first = k;
                width++;
            end
            @(negedge clk);
        end
`ifdef ONEWIRE_PRESENCE_EN
        checks++; if (width != 60) begin errors++; $display("FAIL presence_width got %0d want 60", width); end
        checks++; if (first < 15 || first > 19) begin errors++; $display("FAIL presence_onset got %0d want 15..19", first); end
`else
        checks++; if (width != 0) begin errors++; $display("FAIL no_presence got %0d want 0", width); end
`endif
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busrst_busy got %b want 1", busy); end
        rx_bits = 64'h0;
        run_slots(0, 64, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (rx_bits !== exp_frame) begin errors++; $display("FAIL busrst_stream got %h want %h", rx_bits, exp_frame); end
        checks++; if (crc !== 8'hA2) begin errors++; $display("FAIL busrst_crc got %h want a2", crc); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL busrst_done got %0d want 1", done_total - d0); end
    endtask

    task automatic test_recover_overlap;
        bit b;
        int d;
        int d0;
        d0 = done_total;
        load_frame(ROM_PAYLOAD);
        rx_bits = 64'h0; bad_slots = 0; held15 = 0;
        do_slot(1'b0, 12, b, d);
        rx_bits[0] = b;
        checks++; if (d != 15) begin errors++; $display("FAIL overlap_hold got %0d want 15", d); end
        run_slots(1, 63, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (rx_bits !== ROM_FRAME) begin errors++; $display("FAIL overlap_stream got %h want %h", rx_bits, ROM_FRAME); end
        checks++; if (done_total - d0 != 1) begin errors++; $display("FAIL overlap_done got %0d want 1", done_total - d0); end
        checks++; if (crc !== 8'hA2) begin errors++; $display("FAIL overlap_crc got %h want a2", crc); end
    endtask

    task automatic test_async_reset_mid_drive;
        load_frame(ROM_PAYLOAD);
        rx_bits = 64'h0; bad_slots = 0; held15 = 0;
        run_slots(0, 2, 1'b0);
        master_low = 1'b1;
        @(negedge clk);
        master_low = 1'b0;
        for (int k = 0; k < 10 && !drive_low; k++) @(negedge clk);
        checks++; if (drive_low !== 1'b1) begin errors++; $display("FAIL arst_drive_start got %b want 1", drive_low); end
        checks++; if (crc !== 8'h46) begin errors++; $display("FAIL arst_crc_pre got %h want 46", crc); end
        #2 reset = 1'b0;
        #1;
        checks++; if (drive_low !== 1'b0) begin errors++; $display("FAIL arst_drive got %b want 0", drive_low); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL arst_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL arst_done got %b want 0", done); end
        checks++; if (crc !== 8'h00) begin errors++; $display("FAIL arst_crc got %h want 00", crc); end
        @(negedge clk);
        reset = 1'b1;
        load_frame(ROM_PAYLOAD);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL arst_reload got %b want 1", busy); end
    endtask

    initial begin
        reset      = 1'b0;
        tx_data    = 56'h0;
        tx_start   = 1'b0;
        master_low = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        test_reset;
        test_known_rom;
        test_zero_frame;
        test_ones_busy_start;
        test_bus_reset;
        test_recover_overlap;
        test_async_reset_mid_drive;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
